// File: rtl/calc2_pkg.sv
// calc2 port: shared command/response types and the tag count.
// Imported by the responder and its completion queue.
package calc2_pkg;

   localparam int NUM_TAGS = 4;

   typedef enum logic [3:0] {
      NOP = 4'd0,
      ADD = 4'd1,
      SUB = 4'd2,
      SHL = 4'd5,
      SHR = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OK   = 2'd1,
      ERR  = 2'd2
   } resp_e;

   typedef struct packed {
      resp_e       resp;
      logic [31:0] data;
      logic [1:0]  tag;
   } resp_t;

endpackage

// File: rtl/calc2_resp_fifo.sv
// Completion queue: up to NUM_TAGS pushes per cycle, one pop per cycle.
// When empty, the lowest-index push is presented at the head the same cycle.
module calc2_resp_fifo
   import calc2_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                 c_clk,
   input  logic                 reset,
   input  logic [NUM_TAGS-1:0]  push_vld,
   input  resp_t [NUM_TAGS-1:0] push_data,
   input  logic                 pop,
   output logic                 head_vld,
   output resp_t                head
);

   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   resp_t         mem [QDEPTH];
   logic [AW-1:0] rd_q;
   logic [AW-1:0] wr_q;
   logic [CW-1:0] cnt_q;
   logic [AW-1:0] wpos [NUM_TAGS];
   int            npush;
   resp_t         first;
   logic          do_pop;

   always_comb begin
      npush = 0;
      first = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         wpos[i] = AW'((int'(wr_q) + npush) % QDEPTH);
         if (push_vld[i]) begin
            if (npush == 0) first = push_data[i];
            npush = npush + 1;
         end
      end
   end

   assign head_vld = (cnt_q != '0) || (|push_vld);
   assign head     = (cnt_q != '0) ? mem[rd_q] : first;
   assign do_pop   = pop && head_vld;

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= AW'((int'(wr_q) + npush) % QDEPTH);
         cnt_q <= CW'(int'(cnt_q) + npush - (do_pop ? 1 : 0));
         if (do_pop) rd_q <= AW'((int'(rd_q) + 1) % QDEPTH);
      end
   end

   // Pushed entries are written even when bypassed; rd_q skips past them.
   always_ff @(posedge c_clk) begin
      if (reset) assert (int'(cnt_q) + npush <= QDEPTH);
      for (int i = 0; i < NUM_TAGS; i++)
         if (push_vld[i]) mem[wpos[i]] <= push_data[i];
   end

endmodule

// File: rtl/calc2_port_responder.sv
// Responder for one calc2 port: two-cycle capture, per-tag countdown
// slots, and a completion queue that serialises tagged responses.
module calc2_port_responder
   import calc2_pkg::*;
#(
   parameter int ADD_LAT   = 3,
   parameter int SHIFT_LAT = 2,
   parameter int QDEPTH    = 4
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [3:0]  req_cmd_in,
   input  logic [31:0] req_data_in,
   input  logic [1:0]  req_tag_in,
   output logic [1:0]  out_resp,
   output logic [31:0] out_data,
   output logic [1:0]  out_tag,
   output logic        dup_tag_err
);

   localparam int CNTW = 8;

   typedef enum logic {S_IDLE, S_OP2} cap_e;

   cap_e                 state_q, state_d;
   logic [3:0]           cmd_q;
   logic [1:0]           tag_q;
   logic [31:0]          op1_q;
   logic                 issue, dup;
   logic [32:0]          sum;
   logic [CNTW-1:0]      lat;
   resp_t                alu;
   logic [NUM_TAGS-1:0]  vld_q, done;
   logic [CNTW-1:0]      cnt_q [NUM_TAGS];
   resp_t [NUM_TAGS-1:0] res_q;
   logic                 head_vld;
   resp_t                head;

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      unique case (state_q)
         S_IDLE: if (req_cmd_in != NOP) state_d = S_OP2;
         S_OP2: begin
            issue   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         cmd_q <= '0;
         tag_q <= '0;
         op1_q <= '0;
      end else if (state_q == S_IDLE && req_cmd_in != NOP) begin
         cmd_q <= req_cmd_in;
         tag_q <= req_tag_in;
         op1_q <= req_data_in;
      end
   end

   // Result is computed at issue; req_data_in carries op2 this cycle.
   always_comb begin
      sum      = {1'b0, op1_q} + {1'b0, req_data_in};
      alu      = '0;
      alu.tag  = tag_q;
      alu.resp = ERR;
      lat      = CNTW'(1);
      unique case (1'b1)
         cmd_q == ADD: begin
            lat = CNTW'(ADD_LAT);
            if (!sum[32]) begin
               alu.resp = OK;
               alu.data = sum[31:0];
            end
         end
         cmd_q == SUB: begin
            lat = CNTW'(ADD_LAT);
            if (req_data_in <= op1_q) begin
               alu.resp = OK;
               alu.data = op1_q - req_data_in;
            end
         end
         cmd_q == SHL: begin
            lat      = CNTW'(SHIFT_LAT);
            alu.resp = OK;
            alu.data = op1_q << req_data_in[4:0];
         end
         cmd_q == SHR: begin
            lat      = CNTW'(SHIFT_LAT);
            alu.resp = OK;
            alu.data = op1_q >> req_data_in[4:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_TAGS; i++)
         done[i] = vld_q[i] && (cnt_q[i] == '0);
   end

   // A slot completing this edge is free for a same-edge reissue.
   assign dup = issue && vld_q[tag_q] && !done[tag_q];

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
         res_q <= '0;
         for (int i = 0; i < NUM_TAGS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            if (issue && !dup && tag_q == 2'(i)) begin
               vld_q[i] <= 1'b1;
               cnt_q[i] <= lat - CNTW'(1);
               res_q[i] <= alu;
            end else if (done[i]) begin
               vld_q[i] <= 1'b0;
            end else if (vld_q[i]) begin
               cnt_q[i] <= cnt_q[i] - CNTW'(1);
            end
         end
      end
   end

   calc2_resp_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .c_clk     (c_clk),
      .reset     (reset),
      .push_vld  (done),
      .push_data (res_q),
      .pop       (1'b1),
      .head_vld  (head_vld),
      .head      (head)
   );

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         out_resp    <= '0;
         out_data    <= '0;
         out_tag     <= '0;
         dup_tag_err <= 1'b0;
      end else begin
         out_resp    <= head_vld ? head.resp : IDLE;
         out_data    <= head_vld ? head.data : '0;
         out_tag     <= head_vld ? head.tag : '0;
         dup_tag_err <= dup;
      end
   end

endmodule

// File: tb/tb_calc2_port_responder.sv
// Directed bench for calc2_port_responder: vector table plus
// hand-written collision, duplicate-tag and reset sequences.
module tb_calc2_port_responder;

   logic        c_clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_cmd_in;
   logic [31:0] req_data_in;
   logic [1:0]  req_tag_in;
   logic [1:0]  out_resp;
   logic [31:0] out_data;
   logic [1:0]  out_tag;
   logic        dup_tag_err;

   int total = 0;
   int bad   = 0;

   calc2_port_responder #(.ADD_LAT(3), .SHIFT_LAT(2), .QDEPTH(4)) dut (
      .c_clk       (c_clk),
      .reset       (rst_n),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .req_tag_in  (req_tag_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .dup_tag_err (dup_tag_err)
   );

   always #5 c_clk = ~c_clk;

   typedef struct {
      logic [3:0]  cmd;
      logic [1:0]  tag;
      logic [31:0] op1;
      logic [31:0] op2;
      int          lat;
      logic [1:0]  resp;
      logic [31:0] data;
   } vec_t;

   vec_t v [14];

   task automatic tick;
      @(posedge c_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [1:0] r,
                          input logic [31:0] d, input logic [1:0] t);
      chk({nm, ".resp"}, 32'(out_resp), 32'(r));
      chk({nm, ".data"}, out_data, d);
      chk({nm, ".tag"}, 32'(out_tag), 32'(t));
   endtask

   // Command edge then op2 edge; garbage cmd/tag during op2 must be ignored.
   task automatic send(input logic [3:0] c, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] b);
      req_cmd_in  = c;
      req_tag_in  = t;
      req_data_in = a;
      tick();
      req_cmd_in  = 4'hF;
      req_tag_in  = ~t;
      req_data_in = b;
      tick();
      req_cmd_in  = 4'h0;
      req_tag_in  = 2'd0;
      req_data_in = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nresp;
      int ndup;
      v[0]  = '{4'd1, 2'd1, 32'h30, 32'h20, 3, 2'd1, 32'h50};
      v[1]  = '{4'd1, 2'd0, 32'hFFFFFFFF, 32'h1, 3, 2'd2, 32'h0};
      v[2]  = '{4'd2, 2'd2, 32'h5, 32'h6, 3, 2'd2, 32'h0};
      v[3]  = '{4'd2, 2'd3, 32'h7, 32'h7, 3, 2'd1, 32'h0};
      v[4]  = '{4'd5, 2'd0, 32'h1, 32'h24, 2, 2'd1, 32'h10};
      v[5]  = '{4'd6, 2'd1, 32'h80000000, 32'h1F, 2, 2'd1, 32'h1};
      v[6]  = '{4'd3, 2'd3, 32'hAAAA, 32'h5555, 1, 2'd2, 32'h0};
      v[7]  = '{4'd1, 2'd2, 32'h7FFFFFFF, 32'h80000001, 3, 2'd2, 32'h0};
      v[8]  = '{4'd1, 2'd0, 32'hFFFFFFFE, 32'h1, 3, 2'd1, 32'hFFFFFFFF};
      v[9]  = '{4'd2, 2'd1, 32'h10, 32'h3, 3, 2'd1, 32'hD};
      v[10] = '{4'd5, 2'd2, 32'hDEADBEEF, 32'h21, 2, 2'd1, 32'hBD5B7DDE};
      v[11] = '{4'd6, 2'd3, 32'h12345678, 32'hFFFFFFE0, 2, 2'd1, 32'h12345678};
      v[12] = '{4'd15, 2'd0, 32'h1, 32'h1, 1, 2'd2, 32'h0};
      v[13] = '{4'd4, 2'd1, 32'h9, 32'h9, 1, 2'd2, 32'h0};

      rst_n       = 1'b0;
      req_cmd_in  = 4'h0;
      req_tag_in  = 2'd0;
      req_data_in = 32'h0;
      tick();
      tick();
      chk_out("reset", 2'd0, 32'h0, 2'd0);
      chk("reset.dup", 32'(dup_tag_err), 32'h0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         send(v[i].cmd, v[i].tag, v[i].op1, v[i].op2);
         for (int k = 1; k <= v[i].lat; k++) begin
            tick();
            if (k < v[i].lat)
               chk($sformatf("v%0d.early", i), 32'(out_resp), 32'h0);
         end
         chk_out($sformatf("v%0d", i), v[i].resp, v[i].data, v[i].tag);
         chk($sformatf("v%0d.dup", i), 32'(dup_tag_err), 32'h0);
         tick();
         chk($sformatf("v%0d.after", i), 32'(out_resp), 32'h0);
      end

      // ADD then SHL back-to-back: ADD leaves first, SHL one cycle later
      send(4'd1, 2'd2, 32'h3, 32'h4);
      send(4'd5, 2'd0, 32'h1, 32'h24);
      chk("seqA.idle", 32'(out_resp), 32'h0);
      tick();
      chk_out("seqA.add", 2'd1, 32'h7, 2'd2);
      tick();
      chk_out("seqA.shl", 2'd1, 32'h10, 2'd0);
      tick();
      chk("seqA.after", 32'(out_resp), 32'h0);

      // ADD and invalid command complete on the same edge: tag 0 first
      send(4'd1, 2'd2, 32'h3, 32'h4);
      send(4'd7, 2'd0, 32'h9, 32'h9);
      chk("seqB.idle", 32'(out_resp), 32'h0);
      tick();
      chk_out("seqB.first", 2'd2, 32'h0, 2'd0);
      tick();
      chk_out("seqB.second", 2'd1, 32'h7, 2'd2);
      tick();
      chk("seqB.after", 32'(out_resp), 32'h0);

      // Duplicate tag while outstanding: dropped, single pulse, one response
      send(4'd1, 2'd1, 32'h1, 32'h2);
      send(4'd1, 2'd1, 32'h5, 32'h5);
      chk("seqC.dup", 32'(dup_tag_err), 32'h1);
      tick();
      chk_out("seqC.resp", 2'd1, 32'h3, 2'd1);
      chk("seqC.dupclr", 32'(dup_tag_err), 32'h0);
      nresp = 0;
      ndup  = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (out_resp != 2'd0) nresp++;
         if (dup_tag_err) ndup++;
      end
      chk("seqC.extra_resp", 32'(nresp), 32'h0);
      chk("seqC.extra_dup", 32'(ndup), 32'h0);

      // Tag reissued on the very edge its slot completes
      send(4'd1, 2'd1, 32'h10, 32'h1);
      tick();
      send(4'd2, 2'd1, 32'h9, 32'h4);
      chk_out("seqD.first", 2'd1, 32'h11, 2'd1);
      chk("seqD.dup", 32'(dup_tag_err), 32'h0);
      tick();
      tick();
      tick();
      chk_out("seqD.second", 2'd1, 32'h5, 2'd1);
      tick();

      // Reset with an ADD outstanding discards it
      send(4'd1, 2'd1, 32'h1, 32'h1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("seqE.async", 32'(out_resp), 32'h0);
      tick();
      chk_out("seqE.inreset", 2'd0, 32'h0, 2'd0);
      tick();
      rst_n = 1'b1;
      nresp = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (out_resp != 2'd0) nresp++;
      end
      chk("seqE.noresp", 32'(nresp), 32'h0);
      send(4'd1, 2'd1, 32'h2, 32'h2);
      chk("seqE.nodup", 32'(dup_tag_err), 32'h0);
      tick();
      tick();
      tick();
      chk_out("seqE.new", 2'd1, 32'h4, 2'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
